inst_dispatch_queue: RTL and testbench
======================================

Name: inst_dispatch_queue

Overview:
- N-wide, parametrised dispatch stage between rename and issue/ROB.
- Buffers renamed instructions in a FIFO and compacts valid lanes to the low lanes in program order.
- Allocates ROB indices and store-queue slots from internal tail pointers.
- Dispatches the longest in-order group that fits the free ROB/SQ space and downstream backpressure.

Parameters:
- WIDTH, 2: lanes in and out per cycle.
- DEPTH, 8: buffer entries; power of 2 and >= WIDTH.
- ROB_DEPTH, 16: ROB entries; power of 2.
- SQ_DEPTH, 16: store-queue entries; power of 2.
- PAYLOAD_W, 64: opaque per-instruction payload bits (pc, phy regs, ready bits, bpu info).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  pipeline flush.
- in_valid  in  WIDTH  per-lane valid; holes are allowed.
- in_is_store  in  WIDTH  lane is a store.
- in_exception  in  WIDTH  lane carries an exception.
- in_payload  in  WIDTH*PAYLOAD_W  lane payloads.
- in_ready  out  1  group accepted this cycle if in_ready.
- rob_head  in  log2(ROB_DEPTH)+1  ROB head with wrap bit.
- sq_head  in  log2(SQ_DEPTH)+1  SQ head with wrap bit.
- out_ready  in  1  issue and ROB can accept.
- out_rob_valid  out  WIDTH  lane goes to the ROB.
- out_issue_valid  out  WIDTH  lane goes to the issue queue.
- out_payload  out  WIDTH*PAYLOAD_W  payload.
- out_exception  out  WIDTH  exception flag.
- out_is_store  out  WIDTH  store flag.
- out_rob_idx  out  WIDTH*log2(ROB_DEPTH)  allocated ROB index.
- out_store_num  out  WIDTH*log2(SQ_DEPTH)  allocated SQ slot.
- out_pre_store  out  WIDTH*log2(SQ_DEPTH)  youngest older store slot.
- out_pre_store_ready  out  WIDTH  no older store outstanding.

Behaviour:
- Reset: buffer empty; rob_tail = sq_tail = 0 (wrap bit included); in_ready = 1; all out_* = 0.
- in_ready = (DEPTH - count) >= WIDTH, using count from the start of the cycle. No dependency on in_valid. Dequeues in the same cycle do not free space until the next cycle.
- Enqueue:
  - When in_ready and at least one in_valid bit is set, the valid lanes are packed in ascending lane order and written at the buffer tail.
  - count increases by popcount(in_valid).
  - If in_valid is all-zero, nothing is written.
- Latency: an entry enqueued in cycle t is visible at the outputs in cycle t+1. There is no input-to-output bypass.
- Free space:
  - rob_free = ROB_DEPTH - (rob_tail - rob_head), computed mod 2^(log2+1).
  - sq_free = SQ_DEPTH - (sq_tail - sq_head), computed the same way.
- Candidates: the oldest m = min(WIDTH, count) entries.
- d = the largest prefix length k <= m such that:
  - k <= rob_free, and
  - the number of stores with no exception in the first k entries <= sq_free.
- Per-lane outputs, for lane i < d:
  - out_rob_valid[i] = 1.
  - out_issue_valid[i] = 1 only if no exception in lanes 0..i.
  - out_rob_idx[i] = rob_tail + i.
  - s_i = number of non-excepting stores in lanes < i.
  - out_store_num[i] = sq_tail + s_i.
  - out_pre_store[i] = sq_tail - 1 + s_i.
  - out_pre_store_ready[i] = (sq_head == sq_tail) && (s_i == 0).
- Lanes >= d drive all outputs as 0.
- Excepting stores: they receive no SQ slot; out_is_store is forced to 0 for them.
- Fire when out_ready && d > 0 && !flush:
  - pop d entries;
  - rob_tail += d;
  - sq_tail += number of stores dispatched.
  - Outputs are combinational from the buffer head, so downstream samples them in the fire cycle.
- When out_ready = 0: outputs stay driven and stable; the state is unchanged.
- ROB full or SQ full: d shrinks, possibly to 0. The stall is held without loss.
- flush:
  - highest priority, over enqueue and fire;
  - empties the buffer;
  - sets rob_tail := rob_head and sq_tail := sq_head;
  - in_ready is 1 in the following cycle.
- Reset mid-operation behaves identically to the reset state.
- All pointer arithmetic wraps modulo the power-of-2 depth. The wrap bit distinguishes full from empty.

Test Plan:
- Compaction: WIDTH=2, in_valid=2'b10 with payload B in lane 1, then out_ready=1 → lane 0 = B, out_rob_idx[0]=0, out_rob_valid=2'b01; rob_tail becomes 1.
- Store chain: sq_head=sq_tail=3; dispatch group {store, store} → out_store_num = 3, 4; out_pre_store = 2, 3; out_pre_store_ready = 1, 0; sq_tail becomes 5.
- ROB limit: rob_tail - rob_head = 15 with 2 entries buffered → d=1, only lane 0 valid. Advancing rob_head by 1 on the next cycle dispatches the remaining entry.
- Exception: group {lane0 exception, lane1 store} → out_rob_valid=2'b11, out_issue_valid=2'b00, out_store_num[1]=sq_tail, out_is_store[0]=0.
- Backpressure/full: DEPTH=8, 8 entries enqueued with out_ready=0 → in_ready=0 and outputs stable for 5 cycles. Raising out_ready drains 2 entries per cycle in order.
- Flush/wrap: rob_tail=15 then dispatch 2 → indices 15, 0 with the wrap bit toggled. Asserting flush with rob_head=9 → buffer empty, next out_rob_idx[0]=9.

Source files
------------

// File: rtl/inst_dispatch_queue.sv
// inst_dispatch_queue: compacting dispatch FIFO that allocates ROB indices and store-queue slots
module inst_dispatch_queue #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int ROB_DEPTH = 16,
  parameter int SQ_DEPTH = 16,
  parameter int PAYLOAD_W = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 in_valid,
  input  logic [WIDTH-1:0]                 in_is_store,
  input  logic [WIDTH-1:0]                 in_exception,
  input  logic [WIDTH*PAYLOAD_W-1:0]       in_payload,
  output logic                             in_ready,
  input  logic [$clog2(ROB_DEPTH):0]       rob_head,
  input  logic [$clog2(SQ_DEPTH):0]        sq_head,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_rob_valid,
  output logic [WIDTH-1:0]                 out_issue_valid,
  output logic [WIDTH*PAYLOAD_W-1:0]       out_payload,
  output logic [WIDTH-1:0]                 out_exception,
  output logic [WIDTH-1:0]                 out_is_store,
  output logic [WIDTH*$clog2(ROB_DEPTH)-1:0] out_rob_idx,
  output logic [WIDTH*$clog2(SQ_DEPTH)-1:0]  out_store_num,
  output logic [WIDTH*$clog2(SQ_DEPTH)-1:0]  out_pre_store,
  output logic [WIDTH-1:0]                 out_pre_store_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(ROB_DEPTH);
  localparam int SW = $clog2(SQ_DEPTH);
  localparam int CW = $clog2(WIDTH + 1);
  logic [PAYLOAD_W-1:0] mem_payload [DEPTH];
  logic [DEPTH-1:0] mem_store, mem_exc;
  logic [AW-1:0] head, tail, idx;
  logic [AW:0] count;
  logic [RW:0] rob_tail, rob_free;
  logic [SW:0] sq_tail, sq_free;
  logic [CW-1:0] enq_n, d, st_d, s;
  logic [CW-1:0] pos [WIDTH];
  logic ok, no_exc, st, fire;
  assign in_ready = ((AW+1)'(DEPTH) - count) >= (AW+1)'(WIDTH);
  assign rob_free = (RW+1)'(ROB_DEPTH) - (rob_tail - rob_head);
  assign sq_free = (SW+1)'(SQ_DEPTH) - (sq_tail - sq_head);
  assign fire = out_ready && d != '0 && !flush;
  // slot of each valid lane after squeezing out the holes
  always_comb begin
    enq_n = '0;
    for (int j = 0; j < WIDTH; j++) begin
      pos[j] = enq_n;
      enq_n = enq_n + CW'(in_valid[j]);
    end
  end
  always_comb begin
    d = '0;
    st_d = '0;
    s = '0;
    ok = 1'b1;
    no_exc = 1'b1;
    idx = head;
    st = 1'b0;
    out_rob_valid = '0;
    out_issue_valid = '0;
    out_payload = '0;
    out_exception = '0;
    out_is_store = '0;
    out_rob_idx = '0;
    out_store_num = '0;
    out_pre_store = '0;
    out_pre_store_ready = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = head + AW'(i);
      st = mem_store[idx] & ~mem_exc[idx];
      ok = ok && (AW+1)'(i) < count && (RW+1)'(i + 1) <= rob_free
         && (SW+1)'(s) + (SW+1)'(st) <= sq_free;
      no_exc = no_exc & ~mem_exc[idx];
      if (ok) begin
        d = CW'(i + 1);
        st_d = st_d + CW'(st);
        out_rob_valid[i] = 1'b1;
        out_issue_valid[i] = no_exc;
        out_payload[i*PAYLOAD_W +: PAYLOAD_W] = mem_payload[idx];
        out_exception[i] = mem_exc[idx];
        out_is_store[i] = st;
        out_rob_idx[i*RW +: RW] = rob_tail[RW-1:0] + RW'(i);
        out_store_num[i*SW +: SW] = sq_tail[SW-1:0] + SW'(s);
        out_pre_store[i*SW +: SW] = sq_tail[SW-1:0] - SW'(1) + SW'(s);
        out_pre_store_ready[i] = sq_head == sq_tail && s == '0;
      end
      s = s + CW'(st);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      rob_tail <= '0;
      sq_tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      rob_tail <= rob_head;
      sq_tail <= sq_head;
    end else begin
      if (in_ready) tail <= tail + AW'(enq_n);
      if (fire) begin
        head <= head + AW'(d);
        rob_tail <= rob_tail + (RW+1)'(d);
        sq_tail <= sq_tail + (SW+1)'(st_d);
      end
      count <= count + (in_ready ? (AW+1)'(enq_n) : '0) - (fire ? (AW+1)'(d) : '0);
    end
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < WIDTH; j++) begin
      if (!reset && !flush && in_ready && in_valid[j]) begin
        mem_payload[tail + AW'(pos[j])] <= in_payload[j*PAYLOAD_W +: PAYLOAD_W];
        mem_store[tail + AW'(pos[j])] <= in_is_store[j];
        mem_exc[tail + AW'(pos[j])] <= in_exception[j];
      end
    end
  end
endmodule

// File: tb/tb_inst_dispatch_queue.sv
// tb_inst_dispatch_queue: directed vector table plus queue-based scoreboard for the dispatch queue
module tb_inst_dispatch_queue;
  logic clk = 1'b0, reset, flush, in_ready, out_ready;
  logic [1:0] in_valid, in_is_store, in_exception;
  logic [127:0] in_payload, out_payload;
  logic [4:0] rob_head, sq_head;
  logic [1:0] out_rob_valid, out_issue_valid, out_exception, out_is_store, out_pre_store_ready;
  logic [7:0] out_rob_idx, out_store_num, out_pre_store;
  int pass_cnt = 0, total_cnt = 0;

  typedef struct packed {
    logic irdy;
    logic [1:0] rv, iv, ex, st, psr;
    logic [1:0][63:0] p;
    logic [1:0][3:0] ri, sn, ps;
  } exp_t;
  typedef struct packed {
    logic rst, fl;
    logic [1:0] iv, ist, iex;
    logic [63:0] p0, p1;
    logic [4:0] rh, sh;
    logic ordy;
    exp_t e;
  } vec_t;
  typedef struct packed {
    logic [63:0] p;
    logic st, exc;
  } ent_t;

  ent_t q[$];
  logic [4:0] m_rob, m_sq;
  vec_t tbl[16];

  inst_dispatch_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_is_store(in_is_store),
    .in_exception(in_exception), .in_payload(in_payload), .in_ready(in_ready),
    .rob_head(rob_head), .sq_head(sq_head), .out_ready(out_ready),
    .out_rob_valid(out_rob_valid), .out_issue_valid(out_issue_valid), .out_payload(out_payload),
    .out_exception(out_exception), .out_is_store(out_is_store), .out_rob_idx(out_rob_idx),
    .out_store_num(out_store_num), .out_pre_store(out_pre_store),
    .out_pre_store_ready(out_pre_store_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic exp_t E(logic irdy, logic [1:0] rv, iv, ex, st, psr, logic [63:0] p0, p1,
                             logic [3:0] ri0, ri1, sn0, sn1, ps0, ps1);
    exp_t e;
    e.irdy = irdy; e.rv = rv; e.iv = iv; e.ex = ex; e.st = st; e.psr = psr;
    e.p[0] = p0; e.p[1] = p1; e.ri[0] = ri0; e.ri[1] = ri1;
    e.sn[0] = sn0; e.sn[1] = sn1; e.ps[0] = ps0; e.ps[1] = ps1;
    return e;
  endfunction

  function automatic vec_t V(logic rst, fl, logic [1:0] iv, ist, iex, logic [63:0] p0, p1,
                             logic [4:0] rh, sh, logic ordy, exp_t e);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ist = ist; v.iex = iex; v.p0 = p0; v.p1 = p1;
    v.rh = rh; v.sh = sh; v.ordy = ordy; v.e = e;
    return v;
  endfunction

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] req);
    total_cnt++;
    if (act !== req) $display("FAIL %s: got %h expected %h", nm, act, req);
    else pass_cnt++;
  endtask

  task automatic check_out(string nm, exp_t e);
    cmp({nm, ".in_ready"}, 64'(in_ready), 64'(e.irdy));
    cmp({nm, ".rob_valid"}, 64'(out_rob_valid), 64'(e.rv));
    cmp({nm, ".issue_valid"}, 64'(out_issue_valid), 64'(e.iv));
    cmp({nm, ".exception"}, 64'(out_exception), 64'(e.ex));
    cmp({nm, ".is_store"}, 64'(out_is_store), 64'(e.st));
    cmp({nm, ".pre_store_ready"}, 64'(out_pre_store_ready), 64'(e.psr));
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("%s.payload[%0d]", nm, i), out_payload[i*64 +: 64], e.p[i]);
      cmp($sformatf("%s.rob_idx[%0d]", nm, i), 64'(out_rob_idx[i*4 +: 4]), 64'(e.ri[i]));
      cmp($sformatf("%s.store_num[%0d]", nm, i), 64'(out_store_num[i*4 +: 4]), 64'(e.sn[i]));
      cmp($sformatf("%s.pre_store[%0d]", nm, i), 64'(out_pre_store[i*4 +: 4]), 64'(e.ps[i]));
    end
  endtask

  // expected outputs for the current model state and the heads being driven
  task automatic model(output exp_t e, output int d, output int nst);
    int rob_free, sq_free, s, st;
    logic ok, noexc;
    e = '0;
    e.irdy = (8 - q.size()) >= 2;
    rob_free = 16 - int'(5'(m_rob - rob_head));
    sq_free = 16 - int'(5'(m_sq - sq_head));
    s = 0; ok = 1'b1; noexc = 1'b1; d = 0; nst = 0;
    for (int i = 0; i < 2; i++) begin
      if (i < q.size()) begin
        st = int'(q[i].st && !q[i].exc);
        ok = ok && (i + 1 <= rob_free) && (s + st <= sq_free);
        noexc = noexc && !q[i].exc;
        if (ok) begin
          d = i + 1;
          nst += st;
          e.rv[i] = 1'b1;
          e.iv[i] = noexc;
          e.ex[i] = q[i].exc;
          e.st[i] = st[0];
          e.p[i] = q[i].p;
          e.ri[i] = 4'(m_rob + 5'(i));
          e.sn[i] = 4'(m_sq + 5'(s));
          e.ps[i] = 4'(m_sq - 5'd1 + 5'(s));
          e.psr[i] = sq_head == m_sq && s == 0;
        end
        s += st;
      end else ok = 1'b0;
    end
  endtask

  task automatic step(vec_t v, bit use_tbl, string nm);
    exp_t me;
    int d, nst;
    reset = v.rst; flush = v.fl; in_valid = v.iv; in_is_store = v.ist; in_exception = v.iex;
    in_payload = {v.p1, v.p0}; rob_head = v.rh; sq_head = v.sh; out_ready = v.ordy;
    @(negedge clk);
    model(me, d, nst);
    if (!v.rst) check_out(nm, use_tbl ? v.e : me);
    if (v.rst) begin
      q.delete(); m_rob = '0; m_sq = '0;
    end else if (v.fl) begin
      q.delete(); m_rob = v.rh; m_sq = v.sh;
    end else begin
      if (v.ordy && d > 0) begin
        for (int k = 0; k < d; k++) void'(q.pop_front());
        m_rob = m_rob + 5'(d);
        m_sq = m_sq + 5'(nst);
      end
      if (me.irdy) begin
        if (v.iv[0]) q.push_back('{v.p0, v.ist[0], v.iex[0]});
        if (v.iv[1]) q.push_back('{v.p1, v.ist[1], v.iex[1]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t Z;
    vec_t rv;
    Z = E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_rob = '0; m_sq = '0;
    // {rst, fl, in_valid, is_store, exception, p0, p1, rob_head, sq_head, out_ready, expected}
    tbl[0]  = V(0, 0, 2'b10, 0, 0, 64'hA0, 64'hB1, 0, 0, 0, Z);
    tbl[1]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E(1, 2'b01, 2'b01, 0, 0, 2'b01, 64'hB1, 0, 0, 0, 0, 0, 15, 0));
    tbl[2]  = V(0, 1, 2'b11, 0, 0, 64'hEE, 64'hEF, 1, 3, 1, Z);
    tbl[3]  = V(0, 0, 2'b11, 2'b11, 0, 64'hC0, 64'hC1, 1, 3, 0, Z);
    tbl[4]  = V(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, E(1, 2'b11, 2'b11, 0, 2'b11, 2'b01, 64'hC0, 64'hC1, 1, 2, 3, 4, 2, 3));
    tbl[5]  = V(0, 0, 2'b11, 0, 0, 64'hD0, 64'hD1, 20, 5, 0, Z);
    tbl[6]  = V(0, 0, 0, 0, 0, 0, 0, 20, 5, 1, E(1, 2'b01, 2'b01, 0, 0, 2'b01, 64'hD0, 0, 3, 0, 5, 0, 4, 0));
    tbl[7]  = V(0, 0, 0, 0, 0, 0, 0, 20, 5, 1, Z);
    tbl[8]  = V(0, 0, 0, 0, 0, 0, 0, 21, 5, 1, E(1, 2'b01, 2'b01, 0, 0, 2'b01, 64'hD1, 0, 4, 0, 5, 0, 4, 0));
    tbl[9]  = V(0, 0, 2'b11, 2'b10, 2'b01, 64'hE0, 64'hE1, 5, 5, 0, Z);
    tbl[10] = V(0, 0, 0, 0, 0, 0, 0, 5, 5, 1, E(1, 2'b11, 0, 2'b01, 2'b10, 2'b11, 64'hE0, 64'hE1, 5, 6, 5, 5, 4, 4));
    tbl[11] = V(0, 0, 2'b11, 2'b11, 2'b01, 64'hF0, 64'hF1, 7, 6, 0, Z);
    tbl[12] = V(0, 0, 0, 0, 0, 0, 0, 7, 6, 1, E(1, 2'b11, 0, 2'b01, 2'b10, 2'b11, 64'hF0, 64'hF1, 7, 8, 6, 6, 5, 5));
    tbl[13] = V(0, 0, 2'b11, 2'b01, 0, 64'h90, 64'h91, 9, 23, 0, Z);
    tbl[14] = V(0, 0, 0, 0, 0, 0, 0, 9, 23, 1, Z);
    tbl[15] = V(0, 0, 0, 0, 0, 0, 0, 9, 24, 1, E(1, 2'b11, 2'b11, 0, 2'b01, 0, 64'h90, 64'h91, 9, 10, 7, 8, 6, 7));

    step(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z), 0, "rst");
    step(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z), 0, "rst");
    for (int i = 0; i < 16; i++) step(tbl[i], 1, $sformatf("tbl%0d", i));

    // fill to full with backpressure, hold, then drain two per cycle
    for (int k = 0; k < 4; k++) step(V(0, 0, 2'b11, 0, 0, 64'h20 + 64'(2*k), 64'h21 + 64'(2*k), 11, 8, 0, Z), 0, "fill");
    for (int k = 0; k < 5; k++) step(V(0, 0, 2'b11, 0, 0, 64'hBAD0, 64'hBAD1, 11, 8, 0, Z), 0, "hold");
    step(V(0, 0, 0, 0, 0, 0, 0, 11, 8, 1, E(0, 2'b11, 2'b11, 0, 0, 2'b11, 64'h20, 64'h21, 11, 12, 8, 8, 7, 7)), 1, "drain0");
    for (int k = 0; k < 3; k++) step(V(0, 0, 0, 0, 0, 0, 0, 11, 8, 1, Z), 0, "drain");

    // ROB index wrap and wrap-bit full detection
    step(V(0, 1, 0, 0, 0, 0, 0, 15, 8, 0, Z), 0, "flush15");
    step(V(0, 0, 2'b11, 0, 0, 64'h55, 64'h56, 15, 8, 0, Z), 0, "enq_wrap");
    step(V(0, 0, 0, 0, 0, 0, 0, 15, 8, 1, E(1, 2'b11, 2'b11, 0, 0, 2'b11, 64'h55, 64'h56, 15, 0, 8, 8, 7, 7)), 1, "wrap");
    step(V(0, 0, 2'b01, 0, 0, 64'h57, 0, 1, 8, 0, Z), 0, "enq_w2");
    step(V(0, 0, 0, 0, 0, 0, 0, 1, 8, 1, Z), 1, "wrapfull");
    step(V(0, 0, 0, 0, 0, 0, 0, 17, 8, 1, E(1, 2'b01, 2'b01, 0, 0, 2'b01, 64'h57, 0, 1, 0, 8, 0, 7, 0)), 1, "wrapgo");

    // flush beats both enqueue and fire
    step(V(0, 0, 2'b11, 0, 0, 64'h60, 64'h61, 18, 8, 0, Z), 0, "enq_fl");
    step(V(0, 1, 2'b11, 0, 0, 64'h62, 64'h63, 9, 2, 1, Z), 0, "flush");
    step(V(0, 0, 2'b01, 0, 0, 64'h77, 0, 9, 2, 0, Z), 1, "postflush");
    step(V(0, 0, 0, 0, 0, 0, 0, 9, 2, 1, E(1, 2'b01, 2'b01, 0, 0, 2'b01, 64'h77, 0, 9, 0, 2, 0, 1, 0)), 1, "flushidx");

    // reset while holding entries
    step(V(0, 0, 2'b11, 2'b11, 0, 64'h80, 64'h81, 10, 2, 0, Z), 0, "enq_rst");
    step(V(1, 0, 2'b11, 0, 0, 64'h82, 64'h83, 10, 2, 1, Z), 0, "rstmid");
    step(V(0, 0, 2'b01, 0, 0, 64'h88, 0, 0, 0, 0, Z), 1, "postrst");
    step(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E(1, 2'b01, 2'b01, 0, 0, 2'b01, 64'h88, 0, 0, 0, 0, 0, 15, 0)), 1, "rstidx");

    // random traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      rv = V(0, $urandom_range(0, 24) == 0, 2'($urandom), 2'($urandom),
             {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0},
             {$urandom, $urandom}, {$urandom, $urandom},
             m_rob - 5'($urandom_range(0, 16)), m_sq - 5'($urandom_range(0, 16)),
             $urandom_range(0, 9) < 7, Z);
      step(rv, 0, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
